text_pixel_serializer: RTL and testbench

Scanline front-end for the text display. It walks the character grid and reads the character code for each cell from the text RAM. It presents the code and scan row to the raster font ROM, then serializes the returned 6-bit raster slice into a 1-bit pixel stream paced by a pixel-clock enable. It sits directly upstream of the font ROM, drives its character and row inputs, and consumes its raster output.

---
 rtl/text_pixel_serializer_if.sv | 28 ++
 rtl/text_pixel_serializer.sv | 164 ++++++++++++++++
 tb/tb_text_pixel_serializer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_pixel_serializer_if.sv
// Signal bundle between the text scanline serializer and its raster timing, text RAM and font ROM neighbours.
// The signal names follow the serializer's point of view.
interface text_pixel_serializer_if #(
  parameter int ADDR_W = 10
);
  logic              i_frame_start;
  logic              i_line_start;
  logic              i_pix_en;
  logic [ADDR_W-1:0] o_text_addr;
  logic [5:0]        i_text_char;
  logic [5:0]        o_char;
  logic [2:0]        o_row;
  logic [5:0]        i_raster;
  logic              o_pixel;
  logic              o_active;

  // Environment side: timing generator, text RAM and font ROM.
  modport master (
    output i_frame_start, i_line_start, i_pix_en, i_text_char, i_raster,
    input  o_text_addr, o_char, o_row, o_pixel, o_active
  );

  // Serializer side.
  modport slave (
    input  i_frame_start, i_line_start, i_pix_en, i_text_char, i_raster,
    output o_text_addr, o_char, o_row, o_pixel, o_active
  );
endinterface

// File: rtl/text_pixel_serializer.sv
// Walks the character grid, fetches each code from text RAM, and looks it up in the font ROM.
// The 6-bit raster slices are then serialized into a pixel stream paced by i_pix_en.
module text_pixel_serializer #(
  parameter int COLS   = 40,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  text_pixel_serializer_if.slave  bus
);

  localparam int COL_W = 7;  // col runs 0..COLS, and COLS can be 64

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACTIVE
  } state_t;

  state_t            state, state_n;
  logic [COL_W-1:0]  col;
  logic [5:0]        text_row;
  logic [2:0]        scan_row;
  logic [2:0]        pix_cnt;
  logic [5:0]        shift;
  logic [5:0]        hold;
  logic              hold_valid;
  logic              fetch_p1;    // address issued last edge; RAM data is on i_text_char
  logic              fetch_p2;    // o_char loaded last edge; font data is on i_raster
  logic [ADDR_W-1:0] line_base;   // text_row * COLS, kept incrementally
  logic [ADDR_W-1:0] text_addr;
  logic [5:0]        char_q;
  logic              pixel_q;
  logic              active_q;

  logic in_active;
  logic line_end;
  logic emit;
  logic fetch_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path infers a latch.
    in_active  = 1'b0;
    line_end   = 1'b0;
    emit       = 1'b0;
    fetch_next = 1'b0;
    in_active  = (state == ACTIVE) && !bus.i_frame_start && !bus.i_line_start;
    line_end   = in_active && bus.i_pix_en && (pix_cnt == 3'd0) && (col == COL_W'(COLS));
    emit       = in_active && bus.i_pix_en && !line_end && ((pix_cnt != 3'd0) || hold_valid);
    fetch_next = emit && (pix_cnt == 3'd0) && ((col + COL_W'(1)) < COL_W'(COLS));
  end

  // A line start beats a frame start, because the frame reset has already zeroed the row counters.
  always_comb begin
    state_n = state;
    if (bus.i_line_start) begin
      state_n = FETCH;
    end else if (bus.i_frame_start) begin
      state_n = IDLE;
    end else begin
      case (state)
        FETCH:   if (fetch_p2) state_n = ACTIVE;
        ACTIVE:  if (line_end) state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register sees pre-edge values.
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col        <= '0;
      text_row   <= '0;
      scan_row   <= '0;
      pix_cnt    <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      fetch_p1   <= 1'b0;
      fetch_p2   <= 1'b0;
      line_base  <= '0;
      text_addr  <= '0;
      char_q     <= '0;
      pixel_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      fetch_p1 <= 1'b0;
      fetch_p2 <= fetch_p1;
      if (fetch_p1) char_q <= bus.i_text_char;
      if (fetch_p2) begin
        hold       <= bus.i_raster;
        hold_valid <= 1'b1;
      end

      if (bus.i_frame_start) begin
        text_row   <= '0;
        scan_row   <= '0;
        line_base  <= '0;
        fetch_p2   <= 1'b0;
        hold_valid <= 1'b0;
        pixel_q    <= 1'b0;
        active_q   <= 1'b0;
      end

      if (bus.i_line_start) begin
        // Also taken while ACTIVE, as an abort: the in-flight prefetch is dropped and rows stay put.
        col        <= '0;
        pix_cnt    <= '0;
        text_addr  <= bus.i_frame_start ? '0 : line_base;
        fetch_p1   <= 1'b1;
        fetch_p2   <= 1'b0;
        hold_valid <= 1'b0;
        pixel_q    <= 1'b0;
        active_q   <= 1'b0;
      end else if (line_end) begin
        pixel_q  <= 1'b0;
        active_q <= 1'b0;
        scan_row <= scan_row + 3'd1;
        if (scan_row == 3'd7) begin
          if (text_row == 6'(ROWS - 1)) begin
            text_row  <= '0;
            line_base <= '0;
          end else begin
            text_row  <= text_row + 6'd1;
            line_base <= line_base + ADDR_W'(COLS);
          end
        end
      end else if (emit) begin
        active_q <= 1'b1;
        if (pix_cnt == 3'd0) begin
          pixel_q    <= hold[5];
          shift      <= {hold[4:0], 1'b0};
          hold_valid <= 1'b0;
          if (fetch_next) begin
            text_addr <= text_addr + ADDR_W'(1);
            fetch_p1  <= 1'b1;
          end
        end else begin
          pixel_q <= shift[5];
          shift   <= {shift[4:0], 1'b0};
        end
        if (pix_cnt == 3'd5) begin
          pix_cnt <= '0;
          col     <= col + COL_W'(1);
        end else begin
          pix_cnt <= pix_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.o_text_addr = text_addr;
  assign bus.o_char      = char_q;
  assign bus.o_row       = scan_row;
  assign bus.o_pixel     = pixel_q;
  assign bus.o_active    = active_q;

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Directed bench for text_pixel_serializer on a 2x2 grid, with a behavioural text RAM and font ROM.
// Inputs change 1 ns after each rising edge, and outputs are sampled at the same point.
module tb_text_pixel_serializer;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  text_pixel_serializer_if #(.ADDR_W(10)) bus ();

  text_pixel_serializer #(.COLS(2), .ROWS(2), .ADDR_W(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Text RAM: the word at the address issued on one edge is sampled by the serializer on the next edge.
  logic [5:0] ram [0:3];
  int         chars [0:3];
  initial begin
    chars = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) ram[i] = 6'(chars[i]);
  end
  assign bus.i_text_char = ram[bus.o_text_addr[1:0]];
  // Font ROM model: raster(c, r) = c*8 + r.
  assign bus.i_raster    = 6'((int'(bus.o_char) * 8) + int'(bus.o_row));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
  endtask

  task automatic start_line();
    bus.i_pix_en     = 1'b0;
    bus.i_line_start = 1'b1;
    tick();
    bus.i_line_start = 1'b0;
  endtask

  function automatic logic [11:0] exp_line(input int base, input int row);
    logic [5:0] a;
    logic [5:0] b;
    a = 6'(chars[base] * 8 + row);
    b = 6'(chars[base + 1] * 8 + row);
    return {a, b};
  endfunction

  // Runs the current line to completion with a strobe every 'period' clocks, collecting the pixels shown.
  task automatic capture(input string tag, input int period, output logic [11:0] bits,
                         output int n_str, output int n_clk);
    bit seen;
    bit done;
    seen  = 1'b0;
    done  = 1'b0;
    bits  = '0;
    n_str = 0;
    n_clk = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      bus.i_pix_en = ((cyc % period) == 0);
      tick();
      if (bus.o_active) begin
        seen = 1'b1;
        n_clk++;
        if (bus.i_pix_en) begin
          bits = {bits[10:0], bus.o_pixel};
          n_str++;
        end
      end else if (seen) begin
        done = 1'b1;
      end
    end
    bus.i_pix_en = 1'b0;
    check({tag, "_line_ended"}, 32'(done), 32'd1);
  endtask

  task automatic run_pixels(input int n, output int got);
    got = 0;
    for (int cyc = 0; cyc < 50 && got < n; cyc++) begin
      bus.i_pix_en = 1'b1;
      tick();
      if (bus.o_active) got++;
    end
  endtask

  logic [11:0] bits;
  int          n_str;
  int          n_clk;
  int          got;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_line_start  = 1'b0;
    bus.i_pix_en      = 1'b1;
    tick();
    tick();
    check("rst_pixel",  32'(bus.o_pixel),     32'd0);
    check("rst_active", 32'(bus.o_active),    32'd0);
    check("rst_addr",   32'(bus.o_text_addr), 32'd0);
    check("rst_char",   32'(bus.o_char),      32'd0);
    check("rst_row",    32'(bus.o_row),       32'd0);
    rst          = 1'b0;
    bus.i_pix_en = 1'b0;
    tick();

    // Basic line, strobe every clock: chars 1 and 2 at row 0 -> 8, 16.
    frame_pulse();
    start_line();
    check("l0_addr_first", 32'(bus.o_text_addr), 32'd0);
    capture("l0", 1, bits, n_str, n_clk);
    check("l0_stream",     32'(bits),  32'(12'b001000_010000));
    check("l0_strobes",    32'(n_str), 32'd12);
    check("l0_act_clocks", 32'(n_clk), 32'd12);
    check("l0_addr_last",  32'(bus.o_text_addr), 32'd1);
    check("l0_pixel_end",  32'(bus.o_pixel), 32'd0);
    check("l0_row_next",   32'(bus.o_row),   32'd1);

    // Same line, strobe every third clock.
    frame_pulse();
    start_line();
    capture("slow", 3, bits, n_str, n_clk);
    check("slow_stream",  32'(bits),  32'(12'b001000_010000));
    check("slow_strobes", 32'(n_str), 32'd12);

    // 17 lines after a frame start: the scan row cycles, and the text row wraps after the second character row.
    frame_pulse();
    for (int i = 0; i < 17; i++) begin
      start_line();
      check($sformatf("seq%0d_row", i),  32'(bus.o_row),       32'(i % 8));
      check($sformatf("seq%0d_base", i), 32'(bus.o_text_addr), 32'(((i % 16) < 8) ? 0 : 2));
      capture($sformatf("seq%0d", i), 1, bits, n_str, n_clk);
      check($sformatf("seq%0d_stream", i), 32'(bits),
            32'(exp_line(((i % 16) < 8) ? 0 : 2, i % 8)));
      check($sformatf("seq%0d_strobes", i), 32'(n_str), 32'd12);
    end

    // Abort after 5 pixels at scan row 1.
    start_line();
    run_pixels(5, got);
    check("abort_pre_pixels", 32'(got), 32'd5);
    bus.i_line_start = 1'b1;
    bus.i_pix_en     = 1'b1;
    tick();
    bus.i_line_start = 1'b0;
    check("abort_active", 32'(bus.o_active),    32'd0);
    check("abort_addr",   32'(bus.o_text_addr), 32'd0);
    check("abort_row",    32'(bus.o_row),       32'd1);
    capture("abort_re", 1, bits, n_str, n_clk);
    check("abort_re_stream",  32'(bits),  32'(12'b001001_010001));
    check("abort_re_strobes", 32'(n_str), 32'd12);
    check("abort_row_next",   32'(bus.o_row), 32'd2);

    // Advance to scan row 5, then apply frame start and line start together partway through a line.
    for (int i = 2; i < 5; i++) begin
      start_line();
      capture($sformatf("adv%0d", i), 1, bits, n_str, n_clk);
    end
    check("pre_row5", 32'(bus.o_row), 32'd5);
    start_line();
    run_pixels(3, got);
    bus.i_frame_start = 1'b1;
    bus.i_line_start  = 1'b1;
    bus.i_pix_en      = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    bus.i_line_start  = 1'b0;
    check("fl_row",    32'(bus.o_row),       32'd0);
    check("fl_addr",   32'(bus.o_text_addr), 32'd0);
    check("fl_active", 32'(bus.o_active),    32'd0);
    capture("fl", 1, bits, n_str, n_clk);
    check("fl_stream",  32'(bits),  32'(12'b001000_010000));
    check("fl_strobes", 32'(n_str), 32'd12);

    // Reset partway through a line, with a strobe every clock.
    start_line();
    run_pixels(3, got);
    rst          = 1'b1;
    bus.i_pix_en = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_pixel",  32'(bus.o_pixel),     32'd0);
    check("mrst_active", 32'(bus.o_active),    32'd0);
    check("mrst_addr",   32'(bus.o_text_addr), 32'd0);
    check("mrst_char",   32'(bus.o_char),      32'd0);
    check("mrst_row",    32'(bus.o_row),       32'd0);
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (bus.o_active || bus.o_pixel) got++;
    end
    check("mrst_quiet", 32'(got), 32'd0);
    start_line();
    capture("mrst_re", 1, bits, n_str, n_clk);
    check("mrst_re_stream", 32'(bits), 32'(12'b001000_010000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
